ripple_carry_adder_reg: RTL and testbench



---
 rtl/ripple_carry_adder_reg_if.sv | 38 +++
 rtl/ripple_carry_adder_reg.sv | 56 +++++
 tb/tb_ripple_carry_adder_reg.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/ripple_carry_adder_reg_if.sv
// rtl/ripple_carry_adder_reg_if.sv - operand/result bundle for the registered ripple-carry adder
//
// Purpose: groups the operand inputs and registered result outputs of
// ripple_carry_adder_reg so a datapath can hand the adder a single bundle.
//
// Signals:
//   in_valid   operands/cin valid this cycle (master -> adder)
//   a, b       WIDTH-bit operands (master -> adder)
//   cin        carry into bit 0 (master -> adder)
//   sum        registered WIDTH-bit sum (adder -> master)
//   carry      registered carry out of the MSB stage (adder -> master)
//   overflow   registered two's-complement overflow (adder -> master)
//   out_valid  one-cycle strobe: result updated from an accepted input (adder -> master)
//
// Modports: master drives operands and observes results; slave is the adder.

interface ripple_carry_adder_reg_if #(
  parameter int WIDTH = 4
);
  logic             in_valid;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic [WIDTH-1:0] sum;
  logic             carry;
  logic             overflow;
  logic             out_valid;

  modport master (
    output in_valid, a, b, cin,
    input  sum, carry, overflow, out_valid
  );

  modport slave (
    input  in_valid, a, b, cin,
    output sum, carry, overflow, out_valid
  );
endinterface

// File: rtl/ripple_carry_adder_reg.sv
// rtl/ripple_carry_adder_reg.sv - WIDTH-bit ripple-carry adder with registered sum, carry-out and overflow
//
// Purpose: explicit chain of single-bit full adders (carry of stage i feeds
// stage i+1); the result, carry-out and signed-overflow flag are captured on
// the clock, giving one cycle of latency and one addition per cycle.
//
// Ports:
//   clk   system clock, all state updates on the rising edge
//   rst   synchronous active-high reset; clears all outputs and wins over
//         a simultaneous valid input
//   bus   ripple_carry_adder_reg_if.slave carrying in_valid/a/b/cin in and
//         sum/carry/overflow/out_valid out
//
// When in_valid is low the result registers hold and out_valid drops.

module ripple_carry_adder_reg #(
  parameter int WIDTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  ripple_carry_adder_reg_if.slave  bus
);

  // c[i] is the carry into stage i; c[WIDTH] is the carry out of the MSB.
  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] s;

  assign c[0] = bus.cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    assign s[i]   = bus.a[i] ^ bus.b[i] ^ c[i];
    assign c[i+1] = (bus.a[i] & bus.b[i]) | (bus.a[i] & c[i]) | (bus.b[i] & c[i]);
  end

  // Signed overflow: carry into the MSB differs from carry out of it.
  // For WIDTH=1 the carry into the MSB is cin itself.
  logic ovf;
  assign ovf = c[WIDTH] ^ c[WIDTH-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.sum       <= '0;
      bus.carry     <= 1'b0;
      bus.overflow  <= 1'b0;
      bus.out_valid <= 1'b0;
    end else if (bus.in_valid) begin
      bus.sum       <= s;
      bus.carry     <= c[WIDTH];
      bus.overflow  <= ovf;
      bus.out_valid <= 1'b1;
    end else begin
      bus.out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ripple_carry_adder_reg.sv
// tb/tb_ripple_carry_adder_reg.sv - scoreboard bench for ripple_carry_adder_reg at WIDTH=4 and WIDTH=8

module tb_ripple_carry_adder_reg;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  ripple_carry_adder_reg_if #(.WIDTH(4)) bus4 ();
  ripple_carry_adder_reg_if #(.WIDTH(8)) bus8 ();

  ripple_carry_adder_reg #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
  ripple_carry_adder_reg #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));

  typedef struct {
    logic [7:0] sum;
    logic       carry;
    logic       ovf;
  } res_t;

  res_t q4[$];
  res_t q8[$];

  int n_checks = 0;
  int n_pass   = 0;

  // Reference: plain integer arithmetic on the unsigned and signed views.
  function automatic res_t model(int w, longint a, longint b, longint cin);
    res_t   r;
    longint tot, sa, sb, ss, lim;
    tot     = a + b + cin;
    r.sum   = 8'(tot % (longint'(1) << w));
    r.carry = (tot >= (longint'(1) << w));
    lim     = longint'(1) << (w - 1);
    sa      = (a >= lim) ? a - (longint'(1) << w) : a;
    sb      = (b >= lim) ? b - (longint'(1) << w) : b;
    ss      = sa + sb + cin;
    r.ovf   = (ss > lim - 1) || (ss < -lim);
    return r;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp)
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    else
      n_pass++;
  endtask

  // Drive one cycle of stimulus to both adders, queueing the result each
  // accepted input must produce one cycle later.
  task automatic step(input bit r,
                      input bit v4, input logic [7:0] a4, input logic [7:0] b4, input bit c4,
                      input bit v8, input logic [7:0] a8, input logic [7:0] b8, input bit c8);
    rst           = r;
    bus4.in_valid = v4;
    bus4.a        = a4[3:0];
    bus4.b        = b4[3:0];
    bus4.cin      = c4;
    bus8.in_valid = v8;
    bus8.a        = a8;
    bus8.b        = b8;
    bus8.cin      = c8;
    if (!r && v4) q4.push_back(model(4, longint'(a4[3:0]), longint'(b4[3:0]), longint'(c4)));
    if (!r && v8) q8.push_back(model(8, longint'(a8), longint'(b8), longint'(c8)));
    @(posedge clk);
    #1;
  endtask

  // Monitor side: what the inputs at the last rising edge imply.
  bit   started = 1'b0;
  bit   rst_s, acc4, acc8;
  res_t last4, last8;

  always @(posedge clk) begin
    rst_s = rst;
    acc4  = !rst && bus4.in_valid;
    acc8  = !rst && bus8.in_valid;
    if (rst) started = 1'b1;
  end

  always @(negedge clk) begin
    res_t e;
    if (started) begin
      chk("out_valid4", 64'(bus4.out_valid), 64'(acc4));
      chk("out_valid8", 64'(bus8.out_valid), 64'(acc8));
      if (rst_s) begin
        last4 = '{sum: 8'h0, carry: 1'b0, ovf: 1'b0};
        last8 = '{sum: 8'h0, carry: 1'b0, ovf: 1'b0};
      end else begin
        if (bus4.out_valid) begin
          if (q4.size() == 0) chk("q4_nonempty", 64'd0, 64'd1);
          else last4 = q4.pop_front();
        end
        if (bus8.out_valid) begin
          if (q8.size() == 0) chk("q8_nonempty", 64'd0, 64'd1);
          else last8 = q8.pop_front();
        end
      end
      e = last4;
      chk("sum4",      64'(bus4.sum),      64'(e.sum[3:0]));
      chk("carry4",    64'(bus4.carry),    64'(e.carry));
      chk("overflow4", 64'(bus4.overflow), 64'(e.ovf));
      e = last8;
      chk("sum8",      64'(bus8.sum),      64'(e.sum));
      chk("carry8",    64'(bus8.carry),    64'(e.carry));
      chk("overflow8", 64'(bus8.overflow), 64'(e.ovf));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] ra, rb, rc, rd;
    // Reset with a valid all-ones input present: input must be dropped.
    step(1, 1, 8'hf, 8'hf, 1, 1, 8'hff, 8'hff, 1);
    step(1, 1, 8'hf, 8'hf, 1, 1, 8'hff, 8'hff, 1);
    // Directed vectors (4-bit) alongside 8-bit boundary cases.
    step(0, 1, 8'h3, 8'h5, 0, 1, 8'hff, 8'hff, 1);
    step(0, 1, 8'hf, 8'h1, 0, 1, 8'hff, 8'h00, 1);
    step(0, 1, 8'ha, 8'h5, 1, 1, 8'h7f, 8'h01, 0);
    step(0, 1, 8'hf, 8'hf, 1, 1, 8'h80, 8'h80, 0);
    step(0, 1, 8'hf, 8'h0, 1, 1, 8'h55, 8'haa, 1);
    // Hold: operands change but in_valid is low.
    step(0, 0, 8'h6, 8'h9, 0, 0, 8'h12, 8'h34, 0);
    step(0, 0, 8'h1, 8'h2, 1, 0, 8'h56, 8'h78, 1);
    step(0, 1, 8'h7, 8'h1, 0, 1, 8'h01, 8'h02, 0);
    // Back-to-back random traffic with occasional idle cycles and a reset mid-stream.
    for (int i = 0; i < 300; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rc = 8'($urandom);
      rd = 8'($urandom);
      step((i == 150) || (i == 151),
           ($urandom_range(0, 7) != 0), ra, rb, rc[0],
           ($urandom_range(0, 7) != 0), rc, rd, ra[7]);
    end
    step(0, 0, 8'h0, 8'h0, 0, 0, 8'h0, 8'h0, 0);
    step(0, 0, 8'h0, 8'h0, 0, 0, 8'h0, 8'h0, 0);
    @(negedge clk);
    chk("q4_drained", 64'(q4.size()), 64'd0);
    chk("q8_drained", 64'(q8.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
